// File: rtl/trace_drain_pkg.sv
// Shared types and constants for the trace drain.
// Optional checksum word is selected with TRACE_DRAIN_CHECKSUM_EN.
package trace_drain_pkg;

    localparam logic [7:0] TRACE_SYNC_BYTE     = 8'hA5;
    localparam int         TRACE_PAYLOAD_WORDS = 5;

    // One completed-instruction record, every field already widened to 32 bits.
    typedef struct packed {
        logic [31:0] instr_addr;
        logic [31:0] instr_data;
        logic [31:0] data_addr;
        logic [31:0] time_start;
        logic [31:0] time_end;
    } trace_record_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HEADER,
`ifdef TRACE_DRAIN_CHECKSUM_EN
        ST_PAYLOAD,
        ST_CHECKSUM
`else
        ST_PAYLOAD
`endif
    } drain_state_t;

    // Payload word idx (1..5) of a record; anything else reads as zero.
    function automatic logic [31:0] payload_word(input trace_record_t rec, input logic [2:0] idx);
        case (idx)
            3'd1:    return rec.instr_addr;
            3'd2:    return rec.instr_data;
            3'd3:    return rec.data_addr;
            3'd4:    return rec.time_start;
            3'd5:    return rec.time_end;
            default: return 32'd0;
        endcase
    endfunction

endpackage

// File: rtl/trace_record_fifo.sv
// Synchronous FIFO of trace records with full/empty/level.
// The head entry is read combinationally so the serialiser can pick any
// payload field of the record it is currently sending.
module trace_record_fifo
    import trace_drain_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  trace_record_t            push_data,
    input  logic                     pop,
    output trace_record_t            head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW      = $clog2(DEPTH);
    localparam int LEVEL_W = AW + 1;

    trace_record_t        mem [DEPTH];
    logic [AW-1:0]        wr_ptr_reg;
    logic [AW-1:0]        rd_ptr_reg;
    logic [LEVEL_W-1:0]   level_reg;

    // Storage write; the caller only pushes when there is room (or a pop frees it).
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

    assign head_data = mem[rd_ptr_reg];
    assign full      = (level_reg == LEVEL_W'(DEPTH));
    assign empty     = (level_reg == '0);
    assign level     = level_reg;

endmodule

// File: rtl/trace_drain.sv
// Trace drain: buffers completed-instruction records and serialises each
// into a framed packet of 32-bit words on a valid/ready stream.
// Define TRACE_DRAIN_CHECKSUM_EN to append an XOR checksum word (7-word packets).
module trace_drain
    import trace_drain_pkg::*;
#(
    parameter int INSTR_ADDR_WIDTH = 32,
    parameter int INSTR_DATA_WIDTH = 32,
    parameter int DATA_ADDR_WIDTH  = 32,
    parameter int FIFO_DEPTH       = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          trace_valid_i,
    input  logic [INSTR_ADDR_WIDTH-1:0]   trace_instr_addr_i,
    input  logic [INSTR_DATA_WIDTH-1:0]   trace_instr_data_i,
    input  logic [DATA_ADDR_WIDTH-1:0]    trace_data_addr_i,
    input  logic [31:0]                   trace_time_start_i,
    input  logic [31:0]                   trace_time_end_i,
    output logic [31:0]                   m_tdata_o,
    output logic                          m_tvalid_o,
    input  logic                          m_tready_i,
    output logic                          m_tlast_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic [31:0]                   drop_total_o
);

    localparam int         LEVEL_W  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [2:0] LAST_IDX = 3'(TRACE_PAYLOAD_WORDS);
`ifdef TRACE_DRAIN_CHECKSUM_EN
    localparam bit         CSUM_EN  = 1'b1;
`else
    localparam bit         CSUM_EN  = 1'b0;
`endif

    drain_state_t         state_reg;
    logic [2:0]           word_idx_reg;
    logic [31:0]          tdata_reg;
    logic                 tvalid_reg;
    logic                 tlast_reg;
    logic [15:0]          seq_reg;
    logic [7:0]           drop_pending_reg;
    logic [31:0]          drop_total_reg;

    trace_record_t        in_rec;
    trace_record_t        head_rec;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [LEVEL_W-1:0]   fifo_level;

    logic                 hs;
    logic                 final_hs;
    logic                 header_accept;
    logic                 push_ok;
    logic                 drop;
    logic                 more_queued;
    logic [2:0]           next_idx;
    logic [31:0]          header_word;

    // Narrow inputs are zero-extended into the 32-bit record fields.
    assign in_rec.instr_addr = 32'(trace_instr_addr_i);
    assign in_rec.instr_data = 32'(trace_instr_data_i);
    assign in_rec.data_addr  = 32'(trace_data_addr_i);
    assign in_rec.time_start = trace_time_start_i;
    assign in_rec.time_end   = trace_time_end_i;

    assign hs            = tvalid_reg & m_tready_i;
    assign final_hs      = hs & tlast_reg;
    assign header_accept = hs & (state_reg == ST_HEADER);

    // A final-word pop frees a slot in the same cycle, so a full FIFO still accepts then.
    assign push_ok     = trace_valid_i & (~fifo_full | final_hs);
    assign drop        = trace_valid_i & fifo_full & ~final_hs;
    // Another record is waiting behind the head (or lands this very edge).
    assign more_queued = (fifo_level > LEVEL_W'(1)) | push_ok;
    assign next_idx    = word_idx_reg + 3'd1;
    assign header_word = {TRACE_SYNC_BYTE, drop_pending_reg, seq_reg};

    trace_record_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push_ok),
        .push_data(in_rec),
        .pop      (final_hs),
        .head_data(head_rec),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .level    (fifo_level)
    );

`ifdef TRACE_DRAIN_CHECKSUM_EN
    logic [31:0] csum_reg;

    // Running XOR of the words of the current packet already accepted downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_reg <= '0;
        end else if (final_hs || state_reg == ST_IDLE) begin
            csum_reg <= '0;
        end else if (hs) begin
            csum_reg <= csum_reg ^ tdata_reg;
        end
    end
`endif

    // Packet FSM with registered stream outputs; words only change on a handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            word_idx_reg <= 3'd0;
            tdata_reg    <= '0;
            tvalid_reg   <= 1'b0;
            tlast_reg    <= 1'b0;
            seq_reg      <= '0;
        end else if (final_hs) begin
            // Packet done: chain straight into the next header when one is queued.
            word_idx_reg <= 3'd0;
            tlast_reg    <= 1'b0;
            if (more_queued) begin
                state_reg <= ST_HEADER;
                tdata_reg <= header_word;
            end else begin
                state_reg  <= ST_IDLE;
                tvalid_reg <= 1'b0;
                tdata_reg  <= '0;
            end
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        state_reg  <= ST_HEADER;
                        tvalid_reg <= 1'b1;
                        tlast_reg  <= 1'b0;
                        tdata_reg  <= header_word;
                    end
                end
                ST_HEADER: begin
                    if (hs) begin
                        state_reg    <= ST_PAYLOAD;
                        word_idx_reg <= 3'd1;
                        tdata_reg    <= payload_word(head_rec, 3'd1);
                        tlast_reg    <= 1'b0;
                        seq_reg      <= seq_reg + 16'd1;
                    end
                end
                ST_PAYLOAD: begin
                    if (hs) begin
`ifdef TRACE_DRAIN_CHECKSUM_EN
                        if (word_idx_reg == LAST_IDX) begin
                            state_reg <= ST_CHECKSUM;
                            tdata_reg <= csum_reg ^ tdata_reg;
                            tlast_reg <= 1'b1;
                        end else
`endif
                        begin
                            word_idx_reg <= next_idx;
                            tdata_reg    <= payload_word(head_rec, next_idx);
                            tlast_reg    <= (next_idx == LAST_IDX) && !CSUM_EN;
                        end
                    end
                end
`ifdef TRACE_DRAIN_CHECKSUM_EN
                ST_CHECKSUM: begin
                    // Only leaves on its final handshake, handled above.
                end
`endif
                default: begin
                    state_reg  <= ST_IDLE;
                    tvalid_reg <= 1'b0;
                    tlast_reg  <= 1'b0;
                end
            endcase
        end
    end

    // Drop accounting: pending count is reported in and cleared by each header.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_pending_reg <= '0;
            drop_total_reg   <= '0;
        end else begin
            if (header_accept) begin
                drop_pending_reg <= drop ? 8'd1 : 8'd0;
            end else if (drop && drop_pending_reg != 8'hFF) begin
                drop_pending_reg <= drop_pending_reg + 8'd1;
            end
            if (drop && drop_total_reg != 32'hFFFF_FFFF) begin
                drop_total_reg <= drop_total_reg + 32'd1;
            end
        end
    end

    assign m_tdata_o    = tdata_reg;
    assign m_tvalid_o   = tvalid_reg;
    assign m_tlast_o    = tlast_reg;
    assign fifo_level_o = fifo_level;
    assign drop_total_o = drop_total_reg;

endmodule

// File: tb/tb_trace_drain.sv
// Self-checking bench for trace_drain: expected packets are queued when a
// record is pushed and compared word by word as the stream emits them.
// Build with TRACE_DRAIN_CHECKSUM_EN to exercise 7-word packets.
module tb_trace_drain;
    import trace_drain_pkg::*;

    localparam int DEPTH   = 8;
    localparam int LEVEL_W = $clog2(DEPTH) + 1;
`ifdef TRACE_DRAIN_CHECKSUM_EN
    localparam bit CSUM      = 1'b1;
    localparam int PKT_WORDS = 7;
`else
    localparam bit CSUM      = 1'b0;
    localparam int PKT_WORDS = 6;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                trace_valid_i = 1'b0;
    logic [31:0]         trace_instr_addr_i = '0;
    logic [31:0]         trace_instr_data_i = '0;
    logic [31:0]         trace_data_addr_i = '0;
    logic [31:0]         trace_time_start_i = '0;
    logic [31:0]         trace_time_end_i = '0;
    logic [31:0]         m_tdata_o;
    logic                m_tvalid_o;
    logic                m_tready_i = 1'b0;
    logic                m_tlast_o;
    logic [LEVEL_W-1:0]  fifo_level_o;
    logic [31:0]         drop_total_o;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } exp_t;

    exp_t          exp_q[$];
    int            check_cnt = 0;
    int            pass_cnt = 0;
    int            hs_count = 0;
    logic [15:0]   seq_model = '0;
    trace_record_t recs[11];

    trace_drain #(
        .INSTR_ADDR_WIDTH(32),
        .INSTR_DATA_WIDTH(32),
        .DATA_ADDR_WIDTH (32),
        .FIFO_DEPTH      (DEPTH)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .trace_valid_i     (trace_valid_i),
        .trace_instr_addr_i(trace_instr_addr_i),
        .trace_instr_data_i(trace_instr_data_i),
        .trace_data_addr_i (trace_data_addr_i),
        .trace_time_start_i(trace_time_start_i),
        .trace_time_end_i  (trace_time_end_i),
        .m_tdata_o         (m_tdata_o),
        .m_tvalid_o        (m_tvalid_o),
        .m_tready_i        (m_tready_i),
        .m_tlast_o         (m_tlast_o),
        .fifo_level_o      (fifo_level_o),
        .drop_total_o      (drop_total_o)
    );

    always #5 clk = ~clk;

    // Stream monitor: every handshake pops one expected word from the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && m_tvalid_o && m_tready_i) begin
            hs_count++;
            check_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL stream_word: got %08h last=%0b, required no word", m_tdata_o, m_tlast_o);
            end else begin
                e = exp_q.pop_front();
                if (m_tdata_o !== e.data || m_tlast_o !== e.last) begin
                    $display("FAIL stream_word #%0d: got %08h last=%0b, required %08h last=%0b",
                             hs_count, m_tdata_o, m_tlast_o, e.data, e.last);
                end else begin
                    pass_cnt++;
                    $display("word #%0d: %08h last=%0b ok", hs_count, m_tdata_o, m_tlast_o);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic trace_record_t make_rec(input int i);
        trace_record_t r;
        r.instr_addr = 32'h0000_1000 + 32'(i) * 32'd4;
        r.instr_data = $urandom;
        r.data_addr  = (i % 2 == 1) ? $urandom : 32'd0;
        r.time_start = 32'(i) * 32'd10;
        r.time_end   = 32'(i) * 32'd10 + 32'd4 + $urandom_range(0, 3);
        return r;
    endfunction

    // Queue the packet this record must produce, using the bench's own sequence count.
    task automatic expect_packet(input trace_record_t rec, input logic [7:0] drop);
        logic [31:0] w[6];
        logic [31:0] cs;
        w[0] = {8'hA5, drop, seq_model};
        w[1] = rec.instr_addr;
        w[2] = rec.instr_data;
        w[3] = rec.data_addr;
        w[4] = rec.time_start;
        w[5] = rec.time_end;
        seq_model = seq_model + 16'd1;
        cs = '0;
        for (int i = 0; i < 6; i++) begin
            cs = cs ^ w[i];
            exp_q.push_back({w[i], (i == 5) && !CSUM});
        end
        if (CSUM) begin
            exp_q.push_back({cs, 1'b1});
        end
    endtask

    // One-cycle record pulse; entered and left at 1 time unit after a rising edge.
    task automatic push(input trace_record_t rec);
        trace_valid_i      = 1'b1;
        trace_instr_addr_i = rec.instr_addr;
        trace_instr_data_i = rec.instr_data;
        trace_data_addr_i  = rec.data_addr;
        trace_time_start_i = rec.time_start;
        trace_time_end_i   = rec.time_end;
        tick();
        trace_valid_i = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        trace_valid_i = 1'b0;
        m_tready_i = 1'b0;
        tick();
        tick();
        exp_q.delete();
        seq_model = '0;
        rst = 1'b0;
    endtask

    task automatic wait_hs(input int target, input string name);
        for (int i = 0; i < 200; i++) begin
            if (hs_count >= target) break;
            tick();
        end
        check_cnt++;
        if (hs_count < target) $display("FAIL %s_timeout: handshakes %0d, required %0d", name, hs_count, target);
        else pass_cnt++;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 400; i++) begin
            if (exp_q.size() == 0 && !m_tvalid_o) break;
            tick();
        end
        check_cnt++;
        if (exp_q.size() != 0 || m_tvalid_o !== 1'b0)
            $display("FAIL %s_drain: %0d words outstanding tvalid=%0b, required 0 and 0", name, exp_q.size(), m_tvalid_o);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        tick();
        check_cnt++;
        if (m_tvalid_o !== 1'b0 || m_tlast_o !== 1'b0) $display("FAIL reset_flags: tvalid=%0b tlast=%0b, required 0 0", m_tvalid_o, m_tlast_o);
        else pass_cnt++;
        check_cnt++;
        if (m_tdata_o !== 32'd0) $display("FAIL reset_tdata: got %08h, required 00000000", m_tdata_o);
        else pass_cnt++;
        check_cnt++;
        if (fifo_level_o !== '0 || drop_total_o !== 32'd0) $display("FAIL reset_counts: level=%0d drops=%0d, required 0 0", fifo_level_o, drop_total_o);
        else pass_cnt++;
        rst = 1'b0;
        tick();
        check_cnt++;
        if (m_tvalid_o !== 1'b0) $display("FAIL reset_idle: tvalid=%0b, required 0", m_tvalid_o);
        else pass_cnt++;
        $display("test_reset done");
    endtask

    task automatic test_single();
        trace_record_t r;
        apply_reset();
        m_tready_i = 1'b1;
        r.instr_addr = 32'h0000_0100;
        r.instr_data = 32'h00A0_0093;
        r.data_addr  = 32'd0;
        r.time_start = 32'd10;
        r.time_end   = 32'd14;
        expect_packet(r, 8'd0);
        push(r);
        check_cnt++;
        if (m_tvalid_o !== 1'b0 || fifo_level_o !== 4'd1) $display("FAIL single_latency0: tvalid=%0b level=%0d, required 0 1", m_tvalid_o, fifo_level_o);
        else pass_cnt++;
        tick();
        check_cnt++;
        if (m_tvalid_o !== 1'b1 || m_tdata_o !== 32'hA500_0000) $display("FAIL single_header: tvalid=%0b data=%08h, required 1 a5000000", m_tvalid_o, m_tdata_o);
        else pass_cnt++;
        wait_drain("single");
        $display("test_single done");
    endtask

    task automatic test_back_to_back();
        int base;
        int gaps;
        int guard;
        apply_reset();
        m_tready_i = 1'b1;
        base = hs_count;
        for (int k = 0; k < 3; k++) begin
            recs[k] = make_rec(k);
            expect_packet(recs[k], 8'd0);
            push(recs[k]);
        end
        gaps = 0;
        guard = 0;
        while (hs_count < base + 3 * PKT_WORDS && guard < 100) begin
            if (!m_tvalid_o) gaps++;
            tick();
            guard++;
        end
        check_cnt++;
        if (gaps != 0 || hs_count != base + 3 * PKT_WORDS)
            $display("FAIL b2b_gapless: gaps=%0d words=%0d, required 0 %0d", gaps, hs_count - base, 3 * PKT_WORDS);
        else pass_cnt++;
        wait_drain("b2b");
        $display("test_back_to_back done");
    endtask

    task automatic test_stall();
        int base;
        apply_reset();
        m_tready_i = 1'b1;
        base = hs_count;
        recs[0] = make_rec(5);
        expect_packet(recs[0], 8'd0);
        push(recs[0]);
        wait_hs(base + 2, "stall");
        m_tready_i = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            check_cnt++;
            if (m_tvalid_o !== 1'b1 || m_tdata_o !== recs[0].instr_data || m_tlast_o !== 1'b0)
                $display("FAIL stall_hold c%0d: tvalid=%0b data=%08h last=%0b, required 1 %08h 0",
                         c, m_tvalid_o, m_tdata_o, m_tlast_o, recs[0].instr_data);
            else pass_cnt++;
        end
        m_tready_i = 1'b1;
        wait_drain("stall");
        $display("test_stall done");
    endtask

    task automatic test_overflow();
        int base;
        apply_reset();
        m_tready_i = 1'b1;
        base = hs_count;
        for (int k = 0; k < 11; k++) recs[k] = make_rec(k + 10);
        expect_packet(recs[0], 8'd0);
        push(recs[0]);
        // Let the first header go so later drops are reported in the next header.
        wait_hs(base + 1, "overflow");
        m_tready_i = 1'b0;
        for (int k = 1; k < 11; k++) push(recs[k]);
        check_cnt++;
        if (fifo_level_o !== 4'd8) $display("FAIL overflow_level: got %0d, required 8", fifo_level_o);
        else pass_cnt++;
        check_cnt++;
        if (drop_total_o !== 32'd3) $display("FAIL overflow_drops: got %0d, required 3", drop_total_o);
        else pass_cnt++;
        expect_packet(recs[1], 8'd3);
        for (int k = 2; k < 8; k++) expect_packet(recs[k], 8'd0);
        m_tready_i = 1'b1;
        wait_drain("overflow");
        $display("test_overflow done");
    endtask

    task automatic test_full_pop_push();
        bit found;
        apply_reset();
        for (int k = 0; k < 9; k++) recs[k] = make_rec(k + 30);
        for (int k = 0; k < 8; k++) begin
            expect_packet(recs[k], 8'd0);
            push(recs[k]);
        end
        check_cnt++;
        if (fifo_level_o !== 4'd8) $display("FAIL fullpop_fill: level=%0d, required 8", fifo_level_o);
        else pass_cnt++;
        m_tready_i = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (m_tvalid_o && m_tlast_o) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        m_tready_i = 1'b0;
        check_cnt++;
        if (!found) $display("FAIL fullpop_last_timeout: tlast=%0b, required 1", m_tlast_o);
        else pass_cnt++;
        expect_packet(recs[8], 8'd0);
        m_tready_i = 1'b1;
        push(recs[8]);
        check_cnt++;
        if (fifo_level_o !== 4'd8 || drop_total_o !== 32'd0)
            $display("FAIL fullpop_same_cycle: level=%0d drops=%0d, required 8 0", fifo_level_o, drop_total_o);
        else pass_cnt++;
        wait_drain("fullpop");
        $display("test_full_pop_push done");
    endtask

    task automatic test_reset_mid_packet();
        int base;
        apply_reset();
        m_tready_i = 1'b1;
        base = hs_count;
        recs[0] = make_rec(50);
        recs[1] = make_rec(51);
        expect_packet(recs[0], 8'd0);
        push(recs[0]);
        wait_hs(base + 3, "midrst");
        rst = 1'b1;
        #1;
        check_cnt++;
        if (m_tvalid_o !== 1'b0 || fifo_level_o !== '0 || m_tdata_o !== 32'd0)
            $display("FAIL midrst_clear: tvalid=%0b level=%0d data=%08h, required 0 0 00000000", m_tvalid_o, fifo_level_o, m_tdata_o);
        else pass_cnt++;
        exp_q.delete();
        seq_model = '0;
        tick();
        rst = 1'b0;
        expect_packet(recs[1], 8'd0);
        push(recs[1]);
        tick();
        check_cnt++;
        if (m_tvalid_o !== 1'b1 || m_tdata_o !== 32'hA500_0000)
            $display("FAIL midrst_header: tvalid=%0b data=%08h, required 1 a5000000", m_tvalid_o, m_tdata_o);
        else pass_cnt++;
        wait_drain("midrst");
        $display("test_reset_mid_packet done");
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_overflow();
        test_full_pop_push();
        test_reset_mid_packet();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
